// File: rtl/audio_framer_if.sv
// ---------------------------------------------------------------------------
// audio_framer_if
// Sample-stream bundle around the audio framer.
//   di_en / data_i      : incoming audio samples, one per cycle at most
//   do_en / data_o      : outgoing frame bursts (FRAME_LEN consecutive cycles)
//   do_sof / do_eof     : first / last sample markers of a burst
//   ovf                 : sticky overflow flag (sample dropped on full buffer)
//   frame_cnt           : number of frames committed, wraps at 16 bits
// modport master : the framer itself (consumes samples, drives the frames)
// modport slave  : the environment (sample source and frame sink)
// ---------------------------------------------------------------------------
interface audio_framer_if #(
    parameter int DW = 14
);
    logic                 di_en;
    logic signed [DW-1:0] data_i;
    logic                 do_en;
    logic signed [DW-1:0] data_o;
    logic                 do_sof;
    logic                 do_eof;
    logic                 ovf;
    logic [15:0]          frame_cnt;

    modport master (
        input  di_en, data_i,
        output do_en, data_o, do_sof, do_eof, ovf, frame_cnt
    );

    modport slave (
        output di_en, data_i,
        input  do_en, data_o, do_sof, do_eof, ovf, frame_cnt
    );
endinterface

// File: rtl/audio_framer.sv
// ---------------------------------------------------------------------------
// audio_framer
// Buffers a continuous stream of signed audio samples in a circular RAM and
// replays overlapping frames of FRAME_LEN samples, advancing HOP samples per
// frame, with at least GAP idle cycles between bursts.
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : audio_framer_if.master (sample input, frame output, status)
// ---------------------------------------------------------------------------
module audio_framer #(
    parameter int DW        = 14,
    parameter int FRAME_LEN = 1024,
    parameter int HOP       = 512,
    parameter int BUF_DEPTH = 2048,
    parameter int GAP       = 2
) (
    input  logic           clk,
    input  logic           rst,
    audio_framer_if.master bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_GAPW   = 2'd2;

    localparam logic [AW:0]   C_DEPTH = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0]   C_FRAME = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0]   C_HOP   = (AW+1)'(HOP);
    localparam logic [AW-1:0] C_HOP_A = AW'(HOP);
    localparam logic [AW-1:0] C_KLAST = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] C_ONE_A = AW'(1);
    localparam logic [GW-1:0] C_GLAST = GW'(GAP - 1);
    localparam logic [GW-1:0] C_ONE_G = GW'(1);

    logic [1:0]           r_state;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_base;
    logic [AW-1:0]        r_k;
    logic [AW:0]          r_avail;
    logic [GW-1:0]        r_gap_cnt;
    logic                 r_ovf;
    logic [15:0]          r_frame_cnt;

    logic signed [DW-1:0] r_mem [BUF_DEPTH];
    logic signed [DW-1:0] r_rd_data;
    logic                 r_rd_vld;
    logic                 r_rd_sof;
    logic                 r_rd_eof;
    logic                 r_do_en;
    logic                 r_do_sof;
    logic                 r_do_eof;
    logic signed [DW-1:0] r_data_o;

    logic                 w_full;
    logic                 w_wr_acc;
    logic                 w_stream;
    logic                 w_last_issue;
    logic [AW-1:0]        w_rd_addr;
    logic [AW:0]          w_avail_inc;
    logic [AW:0]          w_avail_dec;

    assign w_full       = (r_avail == C_DEPTH);
    assign w_wr_acc     = bus.di_en & ~w_full;
    assign w_stream     = (r_state == S_STREAM);
    assign w_last_issue = w_stream && (r_k == C_KLAST);
    assign w_rd_addr    = r_rd_base + r_k;   // wraps naturally, depth is 2^AW
    assign w_avail_inc  = {{AW{1'b0}}, w_wr_acc};
    // The free of HOP slots lands on the same edge as the last read issue
    // (entry into the gap state); a write on that edge is still counted.
    assign w_avail_dec  = w_last_issue ? C_HOP : '0;

    // Control: pointers, occupancy, frame sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_base   <= '0;
            r_k         <= '0;
            r_avail     <= '0;
            r_gap_cnt   <= '0;
            r_ovf       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_ONE_A;
            end
            if (bus.di_en && w_full) begin
                r_ovf <= 1'b1;
            end
            r_avail <= r_avail + w_avail_inc - w_avail_dec;

            case (r_state)
                S_IDLE: begin
                    if (r_avail >= C_FRAME) begin
                        r_state <= S_STREAM;
                        r_k     <= '0;
                    end
                end
                S_STREAM: begin
                    r_k <= r_k + C_ONE_A;
                    if (r_k == C_KLAST) begin
                        r_rd_base   <= r_rd_base + C_HOP_A;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_gap_cnt   <= '0;
                        r_state     <= (GAP == 0) ? S_IDLE : S_GAPW;
                    end
                end
                S_GAPW: begin
                    if (r_gap_cnt == C_GLAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + C_ONE_G;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-stage read pipeline: RAM data register, then output register.
    // Markers travel alongside so they line up with the data they tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld <= 1'b0;
            r_rd_sof <= 1'b0;
            r_rd_eof <= 1'b0;
            r_do_en  <= 1'b0;
            r_do_sof <= 1'b0;
            r_do_eof <= 1'b0;
            r_data_o <= '0;
        end else begin
            r_rd_vld <= w_stream;
            r_rd_sof <= w_stream && (r_k == '0);
            r_rd_eof <= w_last_issue;
            r_do_en  <= r_rd_vld;
            r_do_sof <= r_rd_sof;
            r_do_eof <= r_rd_eof;
            r_data_o <= r_rd_vld ? r_rd_data : '0;
        end
    end

    // Sample store: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= bus.data_i;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    assign bus.do_en     = r_do_en;
    assign bus.do_sof    = r_do_sof;
    assign bus.do_eof    = r_do_eof;
    assign bus.data_o    = r_data_o;
    assign bus.ovf       = r_ovf;
    assign bus.frame_cnt = r_frame_cnt;
endmodule
